// File: rtl/starfield_scroll_ctrl.sv
// Frame sequencer for the starfield display LFSR: gates its enable to the star
// window and, once per vertical blank, steps a private seed and parallel-loads it.
module starfield_scroll_ctrl #(
    parameter int          WIN_W     = 256,
    parameter int          WIN_H     = 256,
    parameter logic [15:0] TAPS      = 16'b0001_0000_0000_1011,
    parameter logic [15:0] SEED_INIT = 16'h0001,
    parameter int          SPEED_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8:0]         hpos,
    input  logic [8:0]         vpos,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    output logic               star_enable,
    output logic               lfsr_load,
    output logic [15:0]        lfsr_seed,
    output logic [7:0]         frame_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ADVANCE = 2'd1,
        ST_LOAD    = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    // An all-zero seed would lock the Galois LFSR, so it is replaced.
    localparam logic [15:0] SEED_RST = (SEED_INIT == 16'h0000) ? 16'h0001 : SEED_INIT;
    localparam logic [9:0]  WIN_W_L  = 10'(WIN_W);
    localparam logic [9:0]  WIN_H_L  = 10'(WIN_H);

    function automatic logic [15:0] seed_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? TAPS : 16'h0000);
    endfunction

    state_t               state_q, state_d;
    logic [15:0]          seed_q, seed_d;
    logic [SPEED_W-1:0]   cnt_q, cnt_d;
    logic [7:0]           fc_q, fc_d;
    logic                 first_q, first_d;
    logic                 en_s;
    logic                 load_s;
    logic                 in_window_s;
    logic                 origin_s;
    logic                 vblank_start_s;

    assign in_window_s    = ({1'b0, hpos} < WIN_W_L) && ({1'b0, vpos} < WIN_H_L);
    assign origin_s       = (hpos == 9'd0) && (vpos == 9'd0);
    assign vblank_start_s = (hpos == 9'd0) && ({1'b0, vpos} == WIN_H_L);

    // State, seed, step counter and frame counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            seed_q  <= SEED_RST;
            cnt_q   <= '0;
            fc_q    <= 8'd0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
            first_q <= first_d;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        first_d = first_q;
        en_s    = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                en_s = in_window_s;
                if (vblank_start_s) begin
                    if (pause || (speed == '0)) begin
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d   = speed;
                        state_d = ST_ADVANCE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ADVANCE: begin
                seed_d = seed_step(seed_q);
                cnt_d  = cnt_q - SPEED_W'(1);
                // A zero count cannot be latched; treat it as last step anyway.
                if (cnt_q <= SPEED_W'(1)) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_LOAD: begin
                load_s  = 1'b1;
                first_d = 1'b0;
                state_d = ST_WAIT;
                if (!first_q) begin
                    fc_d = fc_q + 8'd1;
                end else begin
                    fc_d = fc_q;
                end
            end
            ST_WAIT: begin
                if (origin_s) begin
                    en_s    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Strobes are masked while reset is held so the reset state reads all-quiet.
    assign star_enable = en_s & ~reset;
    assign lfsr_load   = load_s & ~reset;
    assign busy        = ((state_q == ST_ADVANCE) || (state_q == ST_LOAD)) & ~reset;
    assign lfsr_seed   = seed_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_starfield_scroll_ctrl.sv
// Scoreboard bench for starfield_scroll_ctrl: stimulus queues expected loads,
// a monitor compares each lfsr_load pulse against the queue.
module tb_starfield_scroll_ctrl;

    logic        clk;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic [3:0]  speed;
    logic        pause;
    logic        star_enable;
    logic        lfsr_load;
    logic [15:0] lfsr_seed;
    logic [7:0]  frame_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int fc_m    = 0;
    logic en_s;
    logic busy_s;

    typedef struct packed {
        logic [15:0] seed;
        logic [7:0]  fc;
    } exp_t;
    exp_t exp_q[$];

    starfield_scroll_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .speed      (speed),
        .pause      (pause),
        .star_enable(star_enable),
        .lfsr_load  (lfsr_load),
        .lfsr_seed  (lfsr_seed),
        .frame_count(frame_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h100B;
        return t;
    endfunction

    // Monitor: every load pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (lfsr_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load: got seed %0h with no load expected", lfsr_seed);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("load_seed", {16'h0, lfsr_seed}, {16'h0, e.seed});
                chk("load_frame_count", {24'h0, frame_count}, {24'h0, e.fc});
            end
        end
    end

    task automatic tick(input int h, input int v);
        hpos = 9'(h);
        vpos = 9'(v);
        @(negedge clk);
        en_s   = star_enable;
        busy_s = busy;
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in WAIT; leaves it in WAIT after the frame load.
    task automatic run_frame(input bit full, input logic [3:0] spd, input bit pse,
                             input logic [3:0] spd_mid, input logic [15:0] exp_seed);
        int n;
        int in_cnt;
        int out_cnt;
        int busy_cnt;
        int vb_en;
        exp_t e;
        n = (pse || spd == 4'd0) ? 0 : int'(spd);
        tick(0, 0);
        chk("origin_enable", {31'h0, en_s}, 32'd1);
        in_cnt  = 1;
        out_cnt = 0;
        if (full) begin
            for (int v = 0; v < 256; v++) begin
                for (int h = 0; h < 258; h++) begin
                    if (!(h == 0 && v == 0)) begin
                        tick(h, v);
                        if (h < 256) in_cnt += int'(en_s);
                        else out_cnt += int'(en_s);
                    end
                end
            end
        end else begin
            tick(1, 0);     in_cnt  += int'(en_s);
            tick(255, 255); in_cnt  += int'(en_s);
            tick(256, 3);   out_cnt += int'(en_s);
            tick(3, 256);   out_cnt += int'(en_s);
            tick(0, 300);   out_cnt += int'(en_s);
        end
        chk("window_enables", 32'(in_cnt), full ? 32'd65536 : 32'd3);
        chk("outside_enables", 32'(out_cnt), 32'd0);
        speed = spd;
        pause = pse;
        e.seed = exp_seed;
        e.fc   = 8'(fc_m);
        exp_q.push_back(e);
        fc_m = (fc_m + 1) % 256;
        tick(0, 256);
        chk("vblank_start_enable", {31'h0, en_s}, 32'd0);
        speed = spd_mid;
        pause = 1'b1;
        busy_cnt = 0;
        vb_en    = 0;
        for (int k = 1; k <= 18; k++) begin
            tick(k, 256);
            busy_cnt += int'(busy_s);
            vb_en    += int'(en_s);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(n + 1));
        chk("vblank_enables", 32'(vb_en), 32'd0);
        chk("frame_count_after", {24'h0, frame_count}, 32'(fc_m));
        chk("seed_hold", {16'h0, lfsr_seed}, {16'h0, exp_seed});
    endtask

    initial begin
        logic [15:0] s15;
        exp_t e;
        reset = 1'b1;
        hpos  = 9'd5;
        vpos  = 9'd300;
        speed = 4'd0;
        pause = 1'b0;
        en_s  = 1'b0;
        busy_s = 1'b0;
        @(posedge clk);
        #1;
        tick(5, 300);
        tick(5, 300);
        chk("rst_load", {31'h0, lfsr_load}, 32'd0);
        chk("rst_enable", {31'h0, star_enable}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_frame_count", {24'h0, frame_count}, 32'd0);
        chk("rst_seed", {16'h0, lfsr_seed}, 32'h0001);

        e.seed = 16'h0001;
        e.fc   = 8'd0;
        exp_q.push_back(e);
        reset = 1'b0;
        tick(5, 300);
        chk("post_reset_busy", {31'h0, busy_s}, 32'd1);
        tick(1, 0);
        chk("wait_enable", {31'h0, en_s}, 32'd0);
        chk("post_reset_frame_count", {24'h0, frame_count}, 32'd0);

        run_frame(1'b0, 4'd3, 1'b0, 4'd9, 16'h0008);
        run_frame(1'b0, 4'd12, 1'b0, 4'd1, 16'h8000);
        run_frame(1'b0, 4'd1, 1'b0, 4'd15, 16'h100B);
        run_frame(1'b1, 4'd2, 1'b0, 4'd7, 16'h402C);
        run_frame(1'b0, 4'd5, 1'b1, 4'd5, 16'h402C);
        run_frame(1'b0, 4'd0, 1'b0, 4'd3, 16'h402C);
        run_frame(1'b0, 4'd0, 1'b1, 4'd3, 16'h402C);
        s15 = 16'h402C;
        for (int i = 0; i < 15; i++) s15 = ref_step(s15);
        run_frame(1'b0, 4'd15, 1'b0, 4'd1, s15);

        // Reset in the middle of a long advance.
        tick(0, 0);
        tick(1, 0);
        speed = 4'd15;
        pause = 1'b0;
        tick(0, 256);
        tick(1, 256);
        tick(2, 256);
        chk("advance_busy", {31'h0, busy_s}, 32'd1);
        reset = 1'b1;
        tick(3, 256);
        chk("midadv_rst_load", {31'h0, lfsr_load}, 32'd0);
        chk("midadv_rst_enable", {31'h0, star_enable}, 32'd0);
        chk("midadv_rst_busy", {31'h0, busy}, 32'd0);
        chk("midadv_rst_frame_count", {24'h0, frame_count}, 32'd0);
        chk("midadv_rst_seed", {16'h0, lfsr_seed}, 32'h0001);
        fc_m = 0;
        e.seed = 16'h0001;
        e.fc   = 8'd0;
        exp_q.push_back(e);
        reset = 1'b0;
        tick(5, 260);
        tick(6, 260);
        chk("midadv_frame_count", {24'h0, frame_count}, 32'd0);
        run_frame(1'b0, 4'd2, 1'b0, 4'd2, 16'h0004);

        tick(7, 260);
        tick(8, 260);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/starfield_scroll_ctrl.md
Name: starfield_scroll_ctrl

Overview:
Frame-level sequencer for the 16-bit star LFSR in the starfield display path.
- Gates the LFSR enable to the 256x256 star window.
- Once per frame, in vertical blank, advances a private seed LFSR by a programmable number of steps.
- Then pulses a parallel load of that seed into the display LFSR, so the field scrolls at a controllable speed, or holds still when paused.
- Sits between hvsync_generator (hpos/vpos) and the LFSR instance.

Parameters:
- WIN_W, 256: star window width in pixels; hpos < WIN_W is inside.
- WIN_H, 256: star window height in lines; vpos < WIN_H is inside.
- TAPS, 16'b1000000001011: feedback taps; must match the display LFSR.
- SEED_INIT, 16'h0001: seed after reset; a value of 0 is replaced by 16'h0001 (no lock-up).
- SPEED_W, 4: width of the speed input.

Ports:
- clk, input, 1: pixel clock.
- reset, input, 1: synchronous, active-high.
- hpos, input, 9: horizontal position from hvsync_generator.
- vpos, input, 9: vertical position from hvsync_generator.
- speed, input, SPEED_W: seed steps per frame.
- pause, input, 1: when 1, no seed advance; field frozen.
- star_enable, output, 1: enable to the display LFSR.
- lfsr_load, output, 1: one-cycle parallel-load strobe to the display LFSR.
- lfsr_seed, output, 16: load value; equals the seed register.
- frame_count, output, 8: completed frames, wraps 255->0.
- busy, output, 1: high in ADVANCE or LOAD.

Behaviour:
- Seed step (Galois, left shift): next = {seed[14:0],1'b0} ^ (seed[15] ? TAPS : 16'h0000).
- FSM states: RUN, ADVANCE, LOAD, WAIT.
- Reset value of every output and register:
  - state = LOAD, seed = SEED_INIT (0 mapped to 1), step counter = 0, frame_count = 0.
  - lfsr_load = 0, star_enable = 0, busy = 0.
- First cycle after reset deasserts: LOAD executes. lfsr_load = 1 with lfsr_seed = SEED_INIT. frame_count is not incremented for this post-reset load. Then WAIT.
- WAIT: star_enable = 1 only in the cycle where hpos==0 && vpos==0. That same cycle transitions to RUN, so pixel (0,0) is enabled.
- RUN:
  - star_enable = (hpos < WIN_W) && (vpos < WIN_H), combinational.
  - On the cycle hpos==0 && vpos==WIN_H:
    - If pause==1 or speed==0, go to LOAD.
    - Otherwise latch counter = speed and go to ADVANCE.
- ADVANCE:
  - One seed step per clock; counter decrements.
  - When counter reaches 1, the step in that cycle is the last one, and the FSM goes to LOAD. Exactly `speed` steps are taken.
  - speed and pause changes during ADVANCE are ignored.
  - star_enable = 0.
- LOAD:
  - lfsr_load = 1 for exactly one cycle; lfsr_seed holds the new seed.
  - frame_count += 1 (mod 256), except for the post-reset LOAD.
  - Then WAIT.
- busy = (state==ADVANCE || state==LOAD).
- lfsr_seed is always driven from the seed register. It is stable outside ADVANCE.
- Latency budget: ADVANCE + LOAD take at most 2^SPEED_W cycles, all within vblank. The display LFSR therefore never sees load and enable in the same cycle.
- Reset mid-ADVANCE or mid-frame: behaves exactly as a power-on reset. The partially stepped seed is discarded.
- Positions outside the 9-bit ranges have no special meaning. Only the equality and compare conditions above are used.

Test Plan:
1. Reset with SEED_INIT=1, then release -> lfsr_load pulses on the 1st cycle with lfsr_seed=16'h0001. frame_count=0, star_enable=0 until (0,0).
2. speed=3, pause=0, run one frame -> at (0,256) busy goes high. Seed steps 0002, 0004, 0008. lfsr_load pulses one cycle with 16'h0008, frame_count=1.
3. Seed 16'h8000, speed=1 -> loaded seed = 16'h100B (msb feedback path).
4. Window gating over a full frame -> star_enable count = exactly 65536 cycles. Zero enables for hpos>=256 or vpos>=256, and zero during ADVANCE/LOAD.
5. pause=1 (or speed=0) for 3 frames -> three lfsr_load pulses with the unchanged seed, frame_count +3, no ADVANCE cycles.
6. Assert reset during ADVANCE with speed=15 -> next cycle all outputs at reset values. The following load carries SEED_INIT and frame_count=0.
